// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared types and helpers for the round-robin encoder arbiter.
package arb_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Expand a binary index into its one-hot grant vector.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_encoder_arbiter_if;
  import arb_pkg::*;

  logic             enable;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  modport master (
    output enable, req,
    input  grant, grant_idx, grant_valid
  );

  modport slave (
    input  enable, req,
    output grant, grant_idx, grant_valid
  );

endinterface

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin search: first set request at or above ptr, wrapping.
module rr_priority_encoder
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    found = |req;
    off   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) begin
        off = IDX_W'(i - 1);
      end
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter: holds one winner until release or hold timeout, then rotates.
module rr_encoder_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 reset,
  rr_encoder_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;

  logic             enc_found;
  logic [IDX_W-1:0] enc_idx;
  logic             hold_release;
  logic             hold_timeout;

  rr_priority_encoder u_enc (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (enc_found),
    .idx   (enc_idx)
  );

  // Hold-counter next value and the two grant-exit conditions.
  always_comb begin
    cnt_d = cnt_q;
    if ((MAX_HOLD != 0) && (cnt_q != HOLD_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
    hold_timeout = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    hold_release = !bus.req[idx_q];
  end

  // Arbitration FSM with registered grant outputs and priority pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable && enc_found) begin
            state_q <= GRANT;
            grant_q <= onehot(enc_idx);
            idx_q   <= enc_idx;
            valid_q <= 1'b1;
            ptr_q   <= enc_idx + 1'b1;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (hold_release || hold_timeout) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Self-checking bench for rr_encoder_arbiter: directed scenarios plus a cycle model.
module tb_rr_encoder_arbiter;

  localparam int MAXH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  rr_encoder_arbiter_if bus_if ();

  rr_encoder_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the resource, how long it has been visible,
  // and where the next round-robin search starts.
  bit          m_init = 1'b0;
  bit          m_busy;
  int          m_idx, m_ptr, m_held, m_win, m_j;
  logic [15:0] m_grant;

  always @(posedge clk) begin
    if (reset) begin
      m_init  = 1'b1;
      m_busy  = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_held  = 0;
      m_grant = '0;
    end else if (m_init) begin
      if (m_busy) begin
        if (!bus_if.req[m_idx] || (MAXH != 0 && m_held == MAXH)) begin
          m_busy  = 1'b0;
          m_grant = '0;
        end else begin
          m_held = m_held + 1;
        end
      end else if (bus_if.enable && bus_if.req != 16'h0) begin
        m_win = -1;
        for (int k = 0; k < 16; k++) begin
          m_j = (m_ptr + k) % 16;
          if (m_win < 0 && bus_if.req[m_j]) m_win = m_j;
        end
        m_busy  = 1'b1;
        m_idx   = m_win;
        m_grant = 16'h1 << m_win;
        m_ptr   = (m_win + 1) % 16;
        m_held  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_grant", bus_if.grant, m_grant);
      chk("model_idx", bus_if.grant_idx, m_idx[3:0]);
      chk("model_valid", bus_if.grant_valid, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (!bus_if.grant_valid && n < 4) begin
      tick();
      n++;
    end
    chk("wait_grant_bound", bus_if.grant_valid, 1);
  endtask

  task automatic measure(input int exp_idx);
    int n;
    chk("to_valid", bus_if.grant_valid, 1);
    chk("to_idx", bus_if.grant_idx, exp_idx);
    n = 0;
    while (bus_if.grant_valid && n < 20) begin
      n++;
      tick();
    end
    chk("to_len", n, 8);
    chk("to_gap", bus_if.grant_valid, 0);
  endtask

  initial begin
    int n;
    int w;
    reset         = 1'b1;
    bus_if.enable = 1'b0;
    bus_if.req    = '0;

    // Reset then single request.
    tick(); tick();
    reset = 1'b0;
    chk("rst_grant", bus_if.grant, 0);
    chk("rst_idx", bus_if.grant_idx, 0);
    chk("rst_valid", bus_if.grant_valid, 0);
    bus_if.enable = 1'b1;
    bus_if.req    = 16'h0001;
    tick();
    chk("single_grant", bus_if.grant, 16'h0001);
    chk("single_idx", bus_if.grant_idx, 0);
    chk("single_valid", bus_if.grant_valid, 1);
    bus_if.req = '0;
    tick();
    chk("single_release", bus_if.grant, 0);
    chk("single_rel_valid", bus_if.grant_valid, 0);

    // Rotation with all requesting; reset first so the pointer starts at 0.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bus_if.req = 16'hFFFF;
    tick();
    for (int k = 0; k <= 16; k++) begin
      wait_grant(n);
      chk("rot_turnaround", n, 0);
      w = k % 16;
      chk("rot_idx", bus_if.grant_idx, w);
      chk("rot_onehot", bus_if.grant, 16'h1 << w);
      bus_if.req[w] = 1'b0;
      tick();
      chk("rot_gap", bus_if.grant_valid, 0);
      if (bus_if.req == 16'h0) bus_if.req = 16'hFFFF;
      tick();
    end
    bus_if.req = '0;
    tick(); tick();

    // Timeout with two persistent requesters.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bus_if.req = 16'h0009;
    tick();
    measure(0);
    tick();
    measure(3);
    tick();
    chk("to_wrap_idx", bus_if.grant_idx, 0);
    chk("to_wrap_valid", bus_if.grant_valid, 1);
    bus_if.req = '0;
    tick(); tick();

    // Enable gating.
    bus_if.enable = 1'b0;
    bus_if.req    = 16'h8000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en_off_valid", bus_if.grant_valid, 0);
    end
    bus_if.enable = 1'b1;
    tick();
    chk("en_grant", bus_if.grant, 16'h8000);
    chk("en_idx", bus_if.grant_idx, 15);
    bus_if.enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_hold", bus_if.grant, 16'h8000);
    end
    bus_if.req = '0;
    tick();
    chk("en_release", bus_if.grant_valid, 0);
    chk("en_idx_holds", bus_if.grant_idx, 15);
    bus_if.enable = 1'b1;

    // Reset mid-grant.
    bus_if.req = 16'h0020;
    tick();
    chk("rm_idx", bus_if.grant_idx, 5);
    reset = 1'b1;
    tick();
    chk("rm_grant0", bus_if.grant, 0);
    chk("rm_valid0", bus_if.grant_valid, 0);
    reset = 1'b0;
    tick();
    chk("rm_regrant", bus_if.grant, 16'h0020);
    chk("rm_regrant_idx", bus_if.grant_idx, 5);
    bus_if.req = '0;
    tick();

    // New request arriving during a grant.
    bus_if.req = 16'h0004;
    tick();
    chk("sim_idx2", bus_if.grant_idx, 2);
    bus_if.req = 16'h0084;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sim_hold", bus_if.grant, 16'h0004);
    end
    bus_if.req = 16'h0080;
    tick();
    chk("sim_gap", bus_if.grant_valid, 0);
    tick();
    chk("sim_grant7", bus_if.grant, 16'h0080);
    chk("sim_idx7", bus_if.grant_idx, 7);
    bus_if.req = '0;
    tick();

    // Randomised traffic, checked by the model only.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0)
        bus_if.req = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      bus_if.enable = ($urandom_range(0, 5) != 0);
      tick();
    end
    bus_if.req = '0;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
